// File: rtl/cpu_core.sv
// Minimal multi-cycle 8-bit CPU: internal ROM, PC, IR and a 4x8 register file
// running a two-state fetch/execute loop. Program image comes from PROG_IMAGE.
module cpu_core #(
    parameter int ROM_DEPTH = 256,
    // Up to 16 words, word 0 in bits [15:0]; all-zero selects the built-in program.
    parameter logic [255:0] PROG_IMAGE = '0
) (
    input logic clk,
    input logic reset
);

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    localparam logic [255:0] DEFAULT_PROG = {176'h0, 16'h8002, 16'h7800,
                                             16'h2100, 16'h1403, 16'h1005};
    localparam logic [255:0] IMAGE = (PROG_IMAGE == '0) ? DEFAULT_PROG : PROG_IMAGE;

    state_t        state, state_d;
    logic [7:0]    pc, pc_d;
    logic [15:0]   ir, ir_d;
    logic [31:0]   regfile, regfile_d;
    logic [15:0]   rom_data;
    logic [3:0]    op;
    logic [1:0]    rd, rs;
    logic [7:0]    imm, rd_val, rs_val;
    logic          wr_en;
    logic [7:0]    wr_val;

    function automatic logic [7:0] rd_reg(input logic [31:0] rf, input logic [1:0] idx);
        return rf[{idx, 3'b000} +: 8];
    endfunction

    assign op     = ir[15:12];
    assign rd     = ir[11:10];
    assign rs     = ir[9:8];
    assign imm    = ir[7:0];
    assign rd_val = rd_reg(regfile, rd);
    assign rs_val = rd_reg(regfile, rs);

    // Words beyond the image (or beyond ROM_DEPTH) read as NOP.
    always_comb begin
        rom_data = '0;
        if (({1'b0, pc} < 9'(ROM_DEPTH)) && (pc[7:4] == 4'h0))
            rom_data = IMAGE[{pc[3:0], 4'b0000} +: 16];
    end

    always_comb begin
        state_d   = state;
        pc_d      = pc;
        ir_d      = ir;
        regfile_d = regfile;
        wr_en     = 1'b0;
        wr_val    = '0;
        case (state)
            FETCH: begin
                ir_d    = rom_data;
                pc_d    = pc + 8'd1;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                case (op)
                    4'h1: begin wr_en = 1'b1; wr_val = imm;             end
                    4'h2: begin wr_en = 1'b1; wr_val = rd_val + rs_val; end
                    4'h3: begin wr_en = 1'b1; wr_val = rd_val - rs_val; end
                    4'h4: begin wr_en = 1'b1; wr_val = rd_val & rs_val; end
                    4'h5: begin wr_en = 1'b1; wr_val = rd_val | rs_val; end
                    4'h6: begin wr_en = 1'b1; wr_val = rd_val ^ rs_val; end
                    4'h7: begin wr_en = 1'b1; wr_val = rs_val;          end
                    4'h8: pc_d = imm;
                    4'h9: if (rd_val == 8'h00) pc_d = imm;
                    4'hF: state_d = HALT;
                    default: ;
                endcase
                if (wr_en)
                    regfile_d[{rd, 3'b000} +: 8] = wr_val;
            end
            HALT: ;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            pc      <= '0;
            ir      <= '0;
            regfile <= '0;
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            ir      <= ir_d;
            regfile <= regfile_d;
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: vector table for the default and custom programs, plus an
// instruction-level reference model driven through randomized async resets.
module tb_cpu_core;

    localparam logic [255:0] BEQ_IMG = {192'h0, 16'hF000, 16'h0000, 16'h9003, 16'h1000};
    localparam logic [255:0] BNE_IMG = {192'h0, 16'h12AA, 16'hF000, 16'h9003, 16'h1001};
    localparam logic [255:0] ALU_IMG = {64'h0, 16'hF000, 16'h2000, 16'h6900, 16'h7800,
                                        16'h5900, 16'h7800, 16'h4900, 16'h7800,
                                        16'h3900, 16'h7800, 16'h143C, 16'h100F};

    logic clk = 1'b0;
    logic rst_main = 1'b1;
    logic rst_aux  = 1'b1;

    always #5 clk = ~clk;

    cpu_core u_main (.clk(clk), .reset(rst_main));
    cpu_core #(.PROG_IMAGE(BEQ_IMG)) u_beq (.clk(clk), .reset(rst_aux));
    cpu_core #(.PROG_IMAGE(BNE_IMG)) u_bne (.clk(clk), .reset(rst_aux));
    cpu_core #(.PROG_IMAGE(ALU_IMG)) u_alu (.clk(clk), .reset(rst_aux));

    typedef struct {
        int          dut;
        int          cyc;
        logic [2:0]  mask;   // [0] pc, [1] ir, [2] regfile
        logic [7:0]  pc;
        logic [15:0] ir;
        logic [31:0] rf;
    } vec_t;

    vec_t vecs[18];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Instruction-level reference model
    logic [15:0] mrom [256];
    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    logic [7:0]  m_rf [4];
    bit          m_exec;
    bit          m_halt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic probe(input int d, output logic [7:0] p, output logic [15:0] i,
                         output logic [31:0] r);
        case (d)
            0:       begin p = u_main.pc; i = u_main.ir; r = u_main.regfile; end
            1:       begin p = u_beq.pc;  i = u_beq.ir;  r = u_beq.regfile;  end
            2:       begin p = u_bne.pc;  i = u_bne.ir;  r = u_bne.regfile;  end
            default: begin p = u_alu.pc;  i = u_alu.ir;  r = u_alu.regfile;  end
        endcase
    endtask

    task automatic model_reset();
        m_pc = '0; m_ir = '0; m_exec = 0; m_halt = 0;
        for (int k = 0; k < 4; k++) m_rf[k] = '0;
    endtask

    task automatic model_clock();
        int a, b, rd, rs;
        if (m_halt) return;
        if (!m_exec) begin
            m_ir   = mrom[m_pc];
            m_pc   = m_pc + 8'd1;
            m_exec = 1;
            return;
        end
        m_exec = 0;
        rd = int'(m_ir[11:10]);
        rs = int'(m_ir[9:8]);
        a  = int'(m_rf[rd]);
        b  = int'(m_rf[rs]);
        case (m_ir[15:12])
            4'h1: m_rf[rd] = m_ir[7:0];
            4'h2: m_rf[rd] = 8'((a + b) % 256);
            4'h3: m_rf[rd] = 8'((a - b + 256) % 256);
            4'h4: m_rf[rd] = 8'(a & b);
            4'h5: m_rf[rd] = 8'(a | b);
            4'h6: m_rf[rd] = 8'(a ^ b);
            4'h7: m_rf[rd] = 8'(b);
            4'h8: m_pc = m_ir[7:0];
            4'h9: if (a == 0) m_pc = m_ir[7:0];
            4'hF: m_halt = 1;
            default: ;
        endcase
    endtask

    task automatic compare_main(input string tag);
        chk({tag, "_pc"}, {24'h0, u_main.pc}, {24'h0, m_pc});
        chk({tag, "_ir"}, {16'h0, u_main.ir}, {16'h0, m_ir});
        chk({tag, "_rf"}, u_main.regfile, {m_rf[3], m_rf[2], m_rf[1], m_rf[0]});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!rst_main) model_clock();
        @(negedge clk);
        compare_main(tag);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        logic [7:0]  p;
        logic [15:0] i;
        logic [31:0] r;
        for (int k = lo; k <= hi; k++) begin
            while (cyc < vecs[k].cyc) begin
                @(posedge clk);
                cyc++;
            end
            #1;
            probe(vecs[k].dut, p, i, r);
            if (vecs[k].mask[0]) chk($sformatf("vec%0d_pc", k), {24'h0, p}, {24'h0, vecs[k].pc});
            if (vecs[k].mask[1]) chk($sformatf("vec%0d_ir", k), {16'h0, i}, {16'h0, vecs[k].ir});
            if (vecs[k].mask[2]) chk($sformatf("vec%0d_rf", k), r, vecs[k].rf);
        end
    endtask

    initial begin
        logic [7:0] prev_r0;
        bit         saw_wrap;

        // default program checkpoints, cycles counted from reset release
        vecs[0]  = '{0,  2, 3'b111, 8'h01, 16'h1005, 32'h00000005};
        vecs[1]  = '{0,  4, 3'b100, 8'h00, 16'h0000, 32'h00000305};
        vecs[2]  = '{0,  6, 3'b100, 8'h00, 16'h0000, 32'h00000308};
        vecs[3]  = '{0,  8, 3'b100, 8'h00, 16'h0000, 32'h00080308};
        vecs[4]  = '{0, 10, 3'b001, 8'h02, 16'h0000, 32'h0};
        vecs[5]  = '{0, 12, 3'b100, 8'h00, 16'h0000, 32'h0008030B};
        // custom programs, sorted by cycle
        vecs[6]  = '{1,  2, 3'b101, 8'h01, 16'h0000, 32'h00000000};
        vecs[7]  = '{2,  2, 3'b100, 8'h00, 16'h0000, 32'h00000001};
        vecs[8]  = '{1,  4, 3'b001, 8'h03, 16'h0000, 32'h0};
        vecs[9]  = '{2,  4, 3'b101, 8'h02, 16'h0000, 32'h00000001};
        vecs[10] = '{1,  6, 3'b111, 8'h04, 16'hF000, 32'h00000000};
        vecs[11] = '{2,  6, 3'b111, 8'h03, 16'hF000, 32'h00000001};
        vecs[12] = '{3,  8, 3'b100, 8'h00, 16'h0000, 32'h00D33C0F};
        vecs[13] = '{3, 12, 3'b100, 8'h00, 16'h0000, 32'h000C3C0F};
        vecs[14] = '{3, 16, 3'b100, 8'h00, 16'h0000, 32'h003F3C0F};
        vecs[15] = '{3, 20, 3'b100, 8'h00, 16'h0000, 32'h00333C0F};
        vecs[16] = '{3, 22, 3'b100, 8'h00, 16'h0000, 32'h00333C1E};
        vecs[17] = '{3, 24, 3'b111, 8'h0C, 16'hF000, 32'h00333C1E};

        for (int k = 0; k < 256; k++) mrom[k] = 16'h0000;
        mrom[0] = 16'h1005; mrom[1] = 16'h1403; mrom[2] = 16'h2100;
        mrom[3] = 16'h7800; mrom[4] = 16'h8002;

        // reset state while reset is held across the first edge
        #8;
        chk("rst_pc", {24'h0, u_main.pc}, 32'h0);
        chk("rst_ir", {16'h0, u_main.ir}, 32'h0);
        chk("rst_rf", u_main.regfile, 32'h0);
        chk("rst_alu_rf", u_alu.regfile, 32'h0);
        #2 rst_main = 1'b0;

        run_vecs(0, 5);

        // reach EXEC of the ADD at address 2, then reset asynchronously
        while (cyc < 17) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk("mid_ir", {16'h0, u_main.ir}, 32'h00002100);
        chk("mid_pc", {24'h0, u_main.pc}, 32'h00000003);
        #2 rst_main = 1'b1;
        #1;
        chk("async_pc", {24'h0, u_main.pc}, 32'h0);
        chk("async_ir", {16'h0, u_main.ir}, 32'h0);
        chk("async_rf", u_main.regfile, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_main = 1'b0;

        // long run: restart plus r0 wrapping past 0xFF
        saw_wrap = 0;
        prev_r0  = 8'h00;
        for (int n = 0; n < 700; n++) begin
            step("run");
            if (prev_r0 == 8'hFE && u_main.regfile[7:0] == 8'h01) saw_wrap = 1;
            prev_r0 = u_main.regfile[7:0];
        end
        chk("wrap_seen", {31'h0, saw_wrap}, 32'h1);
        chk("wrap_r1", {24'h0, u_main.regfile[15:8]}, 32'h03);

        // randomized async resets at arbitrary points in the instruction cycle
        for (int it = 0; it < 15; it++) begin
            int n;
            n = int'($urandom_range(1, 30));
            for (int k = 0; k < n; k++) step("rnd");
            #($urandom_range(1, 3));
            rst_main = 1'b1;
            model_reset();
            #1;
            compare_main("rnd_rst");
            @(negedge clk);
            rst_main = 1'b0;
        end

        // custom programs
        @(negedge clk);
        rst_aux = 1'b0;
        cyc = 0;
        run_vecs(6, 17);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("beq_hold_pc", {24'h0, u_beq.pc}, 32'h04);
            chk("beq_hold_ir", {16'h0, u_beq.ir}, 32'hF000);
            chk("beq_hold_rf", u_beq.regfile, 32'h0);
            chk("bne_hold_pc", {24'h0, u_bne.pc}, 32'h03);
            chk("bne_r0", {24'h0, u_bne.regfile[7:0]}, 32'h01);
            chk("alu_hold_pc", {24'h0, u_alu.pc}, 32'h0C);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
